// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the rate-1/2 hard-decision Viterbi decoder.
package viterbi_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } vstate_t;

    // Octal generator literals already carry the tap mask in their binary bits.
    function automatic logic [7:0] oct2mask(input logic [7:0] oct);
        return oct;
    endfunction

    function automatic int m_of(input int k);
        return k - 1;
    endfunction

    function automatic int ns_of(input int k);
        return 1 << (k - 1);
    endfunction

    function automatic logic parity(input int unsigned v);
        return ^v;
    endfunction

    function automatic int unsigned sat_add(input int unsigned a,
                                            input int unsigned b,
                                            input int          w);
        int unsigned mx;
        mx = (32'd1 << w) - 32'd1;
        return ((a + b) > mx) ? mx : (a + b);
    endfunction

endpackage

// File: rtl/viterbi_decoder_1_2_acs.sv
// Add-compare-select for one trellis state; ties resolve to predecessor 0.
module viterbi_acs_unit
    import viterbi_pkg::*;
#(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm_p0,
    input  logic [PM_W-1:0] pm_p1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_sel,
    output logic            dec
);

    logic [PM_W-1:0] w_c0;
    logic [PM_W-1:0] w_c1;

    assign w_c0   = PM_W'(sat_add(32'(pm_p0), 32'(bm0), PM_W));
    assign w_c1   = PM_W'(sat_add(32'(pm_p1), 32'(bm1), PM_W));
    assign dec    = (w_c1 < w_c0);
    assign pm_sel = dec ? w_c1 : w_c0;

endmodule

// File: rtl/viterbi_decoder_1_2.sv
// Hard-decision Viterbi decoder, rate 1/2, register-exchange survivors.
module viterbi_decoder_1_2
    import viterbi_pkg::*;
#(
    parameter int         K        = 3,
    parameter logic [7:0] G0_OCT   = 8'o07,
    parameter logic [7:0] G1_OCT   = 8'o05,
    parameter int         TB_DEPTH = 15,
    parameter int         PM_W     = 6,
    parameter int         PM_INIT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       in_valid,
    input  logic [1:0] in_sym,
    output logic       in_ready,
    input  logic       flush,
    output logic       out_valid,
    output logic       out_bit,
    output logic       busy
);

    localparam int         M   = m_of(K);
    localparam int         NS  = ns_of(K);
    localparam logic [7:0] G0M = oct2mask(G0_OCT);
    localparam logic [7:0] G1M = oct2mask(G1_OCT);
    localparam int         FW  = $clog2(TB_DEPTH + 1);
    localparam int         IW  = $clog2(TB_DEPTH);

    vstate_t             r_state;
    logic [PM_W-1:0]     r_pm      [NS];
    logic [TB_DEPTH-1:0] r_surv    [NS];
    logic [FW-1:0]       r_fill;
    logic [M-1:0]        r_best;
    logic [M-1:0]        r_fl_state;
    logic [IW-1:0]       r_fl_idx;
    logic                r_out_valid;
    logic                r_out_bit;

    logic [PM_W-1:0]     w_cand    [NS];
    logic [TB_DEPTH-1:0] w_surv_nx [NS];
    logic [PM_W-1:0]     w_min;
    logic [M-1:0]        w_best;
    logic [FW-1:0]       w_fill_nx;
    logic [IW-1:0]       w_fl_start;
    logic                w_acc;
    logic                w_reinit;
    logic                w_emit;

    for (genvar n = 0; n < NS; n++) begin : g_st
        localparam int         B  = n >> (M - 1);
        localparam int         P0 = (n << 1) & (NS - 1);
        localparam int         P1 = P0 | 1;
        localparam int         R0 = (B << M) | P0;
        localparam int         R1 = (B << M) | P1;
        localparam logic [1:0] E0 = {parity(R0 & int'(G0M)),
                                     parity(R0 & int'(G1M))};
        localparam logic [1:0] E1 = {parity(R1 & int'(G0M)),
                                     parity(R1 & int'(G1M))};

        logic [1:0]      w_d0;
        logic [1:0]      w_d1;
        logic [1:0]      w_bm0;
        logic [1:0]      w_bm1;
        logic [PM_W-1:0] w_sel;
        logic            w_dec;

        assign w_d0  = in_sym ^ E0;
        assign w_d1  = in_sym ^ E1;
        assign w_bm0 = {1'b0, w_d0[1]} + {1'b0, w_d0[0]};
        assign w_bm1 = {1'b0, w_d1[1]} + {1'b0, w_d1[0]};

        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm_p0  (r_pm[P0]),
            .pm_p1  (r_pm[P1]),
            .bm0    (w_bm0),
            .bm1    (w_bm1),
            .pm_sel (w_sel),
            .dec    (w_dec)
        );

        assign w_cand[n]    = w_sel;
        assign w_surv_nx[n] = {w_dec ? r_surv[P1][TB_DEPTH-2:0]
                                     : r_surv[P0][TB_DEPTH-2:0],
                               1'(B)};
    end

    // Strict compare keeps the lowest index among equal minima.
    always_comb begin
        w_min  = w_cand[0];
        w_best = '0;
        for (int i = 1; i < NS; i++) begin
            if (w_cand[i] < w_min) begin
                w_min  = w_cand[i];
                w_best = M'(i);
            end
        end
    end

    assign w_acc      = in_valid & (r_state == RUN);
    assign w_fill_nx  = (r_fill == FW'(TB_DEPTH)) ? r_fill : r_fill + 1'b1;
    assign w_fl_start = (r_fill >= FW'(TB_DEPTH - 1)) ? IW'(TB_DEPTH - 2)
                                                       : IW'(r_fill - 1'b1);
    assign w_reinit   = ((r_state == RUN) & ~in_valid & flush
                         & (r_fill == '0))
                      | ((r_state == FLUSH) & (r_fl_idx == '0));
    assign w_emit     = w_acc & (w_fill_nx >= FW'(TB_DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            for (int i = 0; i < NS; i++) begin
                r_pm[i]   <= (i == 0) ? '0 : PM_W'(PM_INIT);
                r_surv[i] <= '0;
            end
            r_fill      <= '0;
            r_best      <= '0;
            r_fl_state  <= '0;
            r_fl_idx    <= '0;
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            if (frame_start || w_reinit) begin
                r_state <= RUN;
                for (int i = 0; i < NS; i++) begin
                    r_pm[i]   <= (i == 0) ? '0 : PM_W'(PM_INIT);
                    r_surv[i] <= '0;
                end
                r_fill  <= '0;
                r_best  <= '0;
            end else if (w_acc) begin
                for (int i = 0; i < NS; i++) begin
                    r_pm[i]   <= w_cand[i] - w_min;
                    r_surv[i] <= w_surv_nx[i];
                end
                r_fill  <= w_fill_nx;
                r_best  <= w_best;
            end else if (r_state == RUN && flush) begin
                r_fl_state <= r_best;
                r_fl_idx   <= w_fl_start;
                r_state    <= FLUSH;
            end else if (r_state == FLUSH) begin
                r_fl_idx <= r_fl_idx - 1'b1;
            end
            // The final flush bit still goes out on the re-initialising edge.
            if (!frame_start) begin
                if (w_emit) begin
                    r_out_valid <= 1'b1;
                    r_out_bit   <= w_surv_nx[w_best][TB_DEPTH-1];
                end else if (r_state == FLUSH) begin
                    r_out_valid <= 1'b1;
                    r_out_bit   <= r_surv[r_fl_state][r_fl_idx];
                end
            end
        end
    end

    assign in_ready  = (r_state == RUN);
    assign busy      = (r_state == FLUSH);
    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;

endmodule

// File: doc/viterbi_decoder_1_2.md
Name: viterbi_decoder_1_2

Overview:
- Hard-decision Viterbi decoder for the rate-1/2 convolutional code produced by conv_encoder_1_2. It uses the same K, G0_OCT and G1_OCT parameters.
- It accepts one 2-bit symbol per cycle. It runs add-compare-select over 2^(K-1) states and keeps survivors by register exchange.
- It emits decoded bits with fixed latency and drains the survivor contents on flush.
- It sits on the receive side, after the channel and slicer.

Parameters:
- K, 3, constraint length (3..7); M = K-1; NS = 2^M.
- G0_OCT, 8'o07, generator for c0 (out_sym bit 1); mask bit i = binary bit i of the octal value.
- G1_OCT, 8'o05, generator for c1 (out_sym bit 0).
- TB_DEPTH, 15, survivor length in bits (>= M+1).
- PM_W, 6, path-metric width.
- PM_INIT, 16, initial metric for non-zero states (< 2^PM_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- frame_start  in  1  pulse: re-initialise metrics and survivors for a new frame
- in_valid  in  1  in_sym valid this cycle
- in_sym  in  2  received symbol {c0,c1}
- in_ready  out  1  decoder accepts symbols (0 during FLUSH)
- flush  in  1  end of frame: drain buffered bits
- out_valid  out  1  out_bit valid (one-cycle qualifier)
- out_bit  out  1  decoded bit, in order
- busy  out  1  FLUSH in progress

Behaviour:
- Trellis is identical to the encoder model:
  - reg_vec = {in_bit, state}; c0 = ^(reg_vec & G0_MASK); c1 = ^(reg_vec & G1_MASK).
  - Next state = {in_bit, state[M-1:1]}.
  - State n has predecessors p_x = {n[M-2:0], x} for x in {0,1}, with decoded bit n[M-1]. For M = 1, p_x = x.
- Branch metric is the Hamming distance (0..2) between in_sym and the expected {c0,c1}.
- ACS (accept = in_valid & in_ready):
  - cand_x = pm[p_x] + bm_x, saturating at 2^PM_W - 1.
  - Select the smaller candidate; on a tie select x = 0.
  - Normalisation: pm_next[n] = cand_sel - min over all n of cand_sel. The stored minimum is therefore always 0.
- Best state = lowest index n with pm_next[n] == 0.
- Survivors: surv_next[n] = {surv[p_sel][TB_DEPTH-2:0], n[M-1]}. Bit 0 is the newest bit.
- fill counts accepted symbols since init and saturates at TB_DEPTH.
- Output on accept edge (registered on the same edge as the state update):
  - If fill_after >= TB_DEPTH: out_valid = 1, out_bit = surv_next[best][TB_DEPTH-1].
  - Symbol j yields bit j-TB_DEPTH+1.
  - Otherwise out_valid = 0.
- FSM with two states, RUN and FLUSH.
- RUN:
  - in_ready = 1.
  - flush = 1 with in_valid = 0 and fill > 0: capture fl_state = current best state and fl_idx = min(fill, TB_DEPTH-1) - 1, then go to FLUSH.
  - flush with fill = 0: re-initialise, stay in RUN, no output.
  - flush with in_valid = 1: the symbol is accepted and flush is ignored.
- FLUSH:
  - in_ready = 0, busy = 1.
  - Each cycle: out_valid = 1, out_bit = surv[fl_state][fl_idx], fl_idx decrements.
  - After the cycle that emits idx 0: re-initialise and return to RUN.
  - in_valid during FLUSH is ignored.
- Initialise (rst, frame_start, or end of flush):
  - pm[0] = 0, pm[n != 0] = PM_INIT.
  - surv = 0, fill = 0, state = RUN.
  - out_valid = 0, out_bit = 0, busy = 0, in_ready = 1.
- frame_start has highest priority: it aborts FLUSH and discards any same-cycle symbol.
- rst mid-frame: everything returns to the reset values immediately (asynchronous reset).
- Guarantees:
  - The total count of out_valid pulses per frame equals the number of accepted symbols.
  - Noiseless input decodes exactly.

Decomposition:
- Package viterbi_pkg holds:
  - the oct2mask function (shared with the encoder bench golden model);
  - M/NS derivation;
  - the PM_W saturating-add helper.
- Sub-module viterbi_acs_unit: one per state. Inputs pm_p0, pm_p1, bm0, bm1. Outputs pm_sel and decision bit x.
- Top level holds the metric registers, min/normalise tree, survivor array, fill counter and FSM.

Test Plan (K=3, G=7,5, TB_DEPTH=15, PM_W=6):
- Reset, no input → out_valid = 0, in_ready = 1, busy = 0. Flush with fill = 0 → no output.
- Symbols 11 10 00 01 01 11 00, then flush → no out_valid during input. busy for exactly 7 cycles; out_bit sequence 1,0,1,1,0,0,0. Then in_ready = 1.
- Same stream with symbol 3 corrupted 00→10 → identical decoded bits 1011000 (single error corrected).
- 200 random bits encoded by conv_encoder_1_2, with random in_valid gaps, then flush → out_valid pulses = 200 and all bits match. Output of bit j occurs on the accept edge of symbol j+14.
- frame_start asserted mid-FLUSH (after 3 of 7 flush bits) → flush aborts, busy = 0 next cycle. Next frame 11 10 then flush → bits 1,0.
- in_valid together with flush in RUN → symbol accepted, no FLUSH entry. Assert rst mid-frame → all outputs at reset values immediately.
